branch_predictor: RTL and testbench

- Dynamic branch predictor feeding the IF stage.
- Direct-mapped table of 2-bit saturating counters plus tags and targets (BHT+BTB).
- Closes the loop with the EX-stage branch resolver: takes its resolved outcome, raises mispredict/redirect, and trains the table.
- Carries a post-reset table-initialisation FSM and saturating performance counters.

---
 rtl/branch_predictor_pkg.sv | 27 ++
 rtl/bp_sat_counter.sv | 22 ++
 rtl/branch_predictor.sv | 158 +++++++++++++++
 tb/tb_branch_predictor.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the branch predictor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default geometry, 2-bit counter encodings, FSM state type,
//           saturating 32-bit increment helper.
package branch_predictor_pkg;

  localparam int BP_XLEN_DEFAULT       = 32;
  localparam int BP_INDEX_BITS_DEFAULT = 6;

  // 2-bit saturating counter encodings; MSB is the taken prediction.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_t;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
// Latency: combinational.
// Backpressure: none.
// Ports: i_ctr current counter, i_taken resolved outcome, o_ctr_next updated counter.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr_next
);

  always_comb begin
    o_ctr_next = i_ctr;
    if (i_taken && (i_ctr != CTR_ST)) begin
      o_ctr_next = i_ctr + 2'd1;
    end else if (!i_taken && (i_ctr != CTR_SNT)) begin
      o_ctr_next = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT+BTB: zero-latency lookup for IF, resolve/train from EX.
// Latency: lookup and mispredict combinational; table/counters update at the clock edge.
// Backpressure: none; not ready during post-reset table initialisation (ENTRIES cycles).
// Ports: clock/reset; if_pc -> pred_taken/pred_target/pred_hit; ready;
//        ex_* resolve inputs -> mispredict/redirect_pc; branch_count/mispredict_count.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN       = BP_XLEN_DEFAULT,
  parameter int INDEX_BITS = BP_INDEX_BITS_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            pred_hit,
  output logic            ready,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = XLEN - INDEX_BITS - 2;

  // Table storage. No reset: the INIT sweep is what clears it.
  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];

  bp_state_t            r_state;
  bp_state_t            w_state_next;
  logic [INDEX_BITS-1:0] r_init_idx;
  logic [31:0]          r_branch_count;
  logic [31:0]          r_mispredict_count;

  logic                  w_run;
  logic [INDEX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0]   w_if_tag;
  logic                  w_if_hit;
  logic                  w_if_taken;
  logic [INDEX_BITS-1:0] w_ex_idx;
  logic [TAG_BITS-1:0]   w_ex_tag;
  logic                  w_ex_hit;
  logic [1:0]            w_ctr_next;
  logic                  w_mispredict;
  logic                  w_unused_pc_lsbs;

  assign w_run = (r_state == BP_RUN);

  // Instruction-aligned PCs: the two LSBs carry no information.
  assign w_unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= BP_INIT;
      r_init_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == BP_INIT) begin
        r_init_idx <= r_init_idx + INDEX_BITS'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BP_INIT: if (&r_init_idx) w_state_next = BP_RUN;
      BP_RUN:  w_state_next = BP_RUN;
      default: w_state_next = BP_INIT;
    endcase
  end

  // ---------------- Lookup (reads pre-update table, no bypass) ----------------
  assign w_if_idx   = if_pc[INDEX_BITS+1:2];
  assign w_if_tag   = if_pc[XLEN-1:INDEX_BITS+2];
  assign w_if_hit   = w_run & r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
  assign w_if_taken = w_if_hit & r_ctr[w_if_idx][1];

  assign pred_hit    = w_if_hit;
  assign pred_taken  = w_if_taken;
  assign pred_target = w_if_taken ? r_target[w_if_idx] : (if_pc + XLEN'(4));
  assign ready       = w_run;

  // ---------------- Resolve ----------------
  assign w_ex_idx = ex_pc[INDEX_BITS+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:INDEX_BITS+2];
  assign w_ex_hit = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);

  // A taken branch with the right direction but a stale target still flushes.
  assign w_mispredict = w_run & ex_valid &
                        ((ex_taken != ex_pred_taken) |
                         (ex_taken & (ex_target != ex_pred_target)));

  assign mispredict  = w_mispredict;
  assign redirect_pc = (w_run & ex_taken) ? ex_target : (ex_pc + XLEN'(4));

  bp_sat_counter u_sat_counter (
    .i_ctr      (r_ctr[w_ex_idx]),
    .i_taken    (ex_taken),
    .o_ctr_next (w_ctr_next)
  );

  // ---------------- Table write: INIT sweep or training ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == BP_INIT) begin
        r_valid[r_init_idx]  <= 1'b0;
        r_tag[r_init_idx]    <= '0;
        r_ctr[r_init_idx]    <= CTR_WNT;
        r_target[r_init_idx] <= '0;
      end else if (ex_valid) begin
        if (w_ex_hit) begin
          r_ctr[w_ex_idx] <= w_ctr_next;
          if (ex_taken) begin
            r_target[w_ex_idx] <= ex_target;
          end
        end else if (ex_taken) begin
          // Miss on a taken branch: (re)allocate, starting weakly taken.
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_ctr[w_ex_idx]    <= CTR_WT;
          r_target[w_ex_idx] <= ex_target;
        end
      end
    end
  end

  // ---------------- Statistics ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_run && ex_valid) begin
        r_branch_count <= sat_inc32(r_branch_count);
      end
      if (w_mispredict) begin
        r_mispredict_count <= sat_inc32(r_mispredict_count);
      end
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic
// compared against a behavioural table model.
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  always #5 clock = ~clock;

  branch_predictor dut (
    .clock            (clock),
    .reset            (reset),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .pred_hit         (pred_hit),
    .ready            (ready),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- Reference model ----------------
  bit          m_run;
  int          m_init_cnt;
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  int          m_ctr   [64];
  logic [31:0] m_tgt   [64];
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic logic [23:0] tag_of(input logic [31:0] pc);
    return 24'(pc / 256);
  endfunction

  function automatic logic [31:0] sat_plus(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic bit model_mispredict();
    return m_run && ex_valid &&
           ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
  endfunction

  task automatic check_outputs();
    int          i;
    bit          hit;
    bit          tk;
    logic [31:0] tgt;
    logic [31:0] redir;
    i     = idx_of(if_pc);
    hit   = m_run && m_valid[i] && (m_tag[i] == tag_of(if_pc));
    tk    = hit && (m_ctr[i] >= 2);
    tgt   = tk ? m_tgt[i] : if_pc + 32'd4;
    redir = (m_run && ex_taken) ? ex_target : ex_pc + 32'd4;
    check_val("ready", ready, m_run);
    check_val("pred_hit", pred_hit, hit);
    check_val("pred_taken", pred_taken, tk);
    check_val("pred_target", pred_target, tgt);
    check_val("mispredict", mispredict, model_mispredict());
    check_val("redirect_pc", redirect_pc, redir);
    check_val("branch_count", branch_count, m_bcnt);
    check_val("mispredict_count", mispredict_count, m_mcnt);
  endtask

  task automatic model_edge();
    int i;
    if (reset) begin
      m_run      = 1'b0;
      m_init_cnt = 0;
      m_bcnt     = '0;
      m_mcnt     = '0;
      for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
    end else if (!m_run) begin
      m_init_cnt++;
      if (m_init_cnt == 64) m_run = 1'b1;
    end else if (ex_valid) begin
      if (model_mispredict()) m_mcnt = sat_plus(m_mcnt);
      m_bcnt = sat_plus(m_bcnt);
      i = idx_of(ex_pc);
      if (m_valid[i] && (m_tag[i] == tag_of(ex_pc))) begin
        if (ex_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = ex_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (ex_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(ex_pc);
        m_ctr[i]   = 2;
        m_tgt[i]   = ex_target;
      end
    end
  endtask

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] ipc, input logic ev, input logic [31:0] epc,
                       input logic et, input logic [31:0] etg,
                       input logic ept, input logic [31:0] eptg);
    if_pc          = ipc;
    ex_valid       = ev;
    ex_pc          = epc;
    ex_taken       = et;
    ex_target      = etg;
    ex_pred_taken  = ept;
    ex_pred_target = eptg;
    #1;
    check_outputs();
  endtask

  task automatic look(input logic [31:0] ipc);
    drive(ipc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [5:0]  ix;
    logic [23:0] tg;
    case ($urandom_range(0, 3))
      0: ix = 6'd0;
      1: ix = 6'd1;
      2: ix = 6'd2;
      default: ix = 6'd63;
    endcase
    case ($urandom_range(0, 3))
      0: tg = 24'd0;
      1: tg = 24'd1;
      2: tg = 24'd2;
      default: tg = 24'hFF_FFFF;
    endcase
    return {tg, ix, 2'b00};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] tg;
    m_bcnt = '0;
    m_mcnt = '0;

    // Reset held 3 cycles.
    reset = 1'b1;
    if_pc = 32'h100; ex_valid = 1'b0; ex_pc = 32'h0; ex_taken = 1'b0;
    ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    tick();
    repeat (2) begin
      look(32'h100);
      tick();
    end

    // INIT sweep: 64 cycles not ready, resolves ignored.
    reset = 1'b0;
    for (int c = 0; c < 64; c++) begin
      drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
      check_val("init_ready", ready, 1'b0);
      check_val("init_mispredict", mispredict, 1'b0);
      tick();
    end
    look(32'h100);
    check_val("ready_after_init", ready, 1'b1);
    check_val("cold_hit", pred_hit, 1'b0);
    check_val("cold_target", pred_target, 32'h104);
    tick();

    // First taken resolve allocates.
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    check_val("alloc_mispredict", mispredict, 1'b1);
    check_val("alloc_redirect", redirect_pc, 32'h80);
    tick();
    look(32'h100);
    check_val("alloc_mcnt", mispredict_count, 32'd1);
    check_val("alloc_hit", pred_hit, 1'b1);
    check_val("alloc_taken", pred_taken, 1'b1);
    check_val("alloc_target", pred_target, 32'h80);
    tick();

    // Train up to strongly taken, then down.
    repeat (2) begin
      drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      check_val("train_up_mispredict", mispredict, 1'b0);
      tick();
    end
    repeat (2) begin
      drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      check_val("train_dn_mispredict", mispredict, 1'b1);
      check_val("train_dn_redirect", redirect_pc, 32'h104);
      tick();
    end
    look(32'h100);
    check_val("wnt_taken", pred_taken, 1'b0);
    tick();
    drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    check_val("snt_mispredict", mispredict, 1'b0);
    tick();

    // Back to weakly taken, then a target change.
    repeat (2) begin
      drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      tick();
    end
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    check_val("tgt_mispredict", mispredict, 1'b1);
    check_val("tgt_redirect", redirect_pc, 32'h90);
    tick();
    look(32'h100);
    check_val("tgt_new", pred_target, 32'h90);
    tick();

    // Alias in index 0 and same-cycle lookup/update.
    look(32'h200);
    check_val("alias_hit", pred_hit, 1'b0);
    tick();
    drive(32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    check_val("samecyc_hit", pred_hit, 1'b0);
    tick();
    look(32'h200);
    check_val("replaced_hit", pred_hit, 1'b1);
    check_val("replaced_target", pred_target, 32'h300);
    tick();
    look(32'h100);
    check_val("evicted_hit", pred_hit, 1'b0);
    tick();

    // PC wrap at the top of the address space.
    look(32'hFFFF_FFFC);
    check_val("wrap_target", pred_target, 32'h0);
    tick();

    // One-cycle reset pulse wipes everything.
    reset = 1'b1;
    look(32'h100);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 64; c++) begin
      drive(32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
      check_val("rst_ready", ready, 1'b0);
      check_val("rst_mispredict", mispredict, 1'b0);
      check_val("rst_bcnt", branch_count, 32'd0);
      tick();
    end
    look(32'h200);
    check_val("rst_wiped_hit", pred_hit, 1'b0);
    check_val("rst_bcnt_final", branch_count, 32'd0);
    check_val("rst_mcnt_final", mispredict_count, 32'd0);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      pc    = rand_pc();
      tg    = rand_pc();
      drive(($urandom_range(0, 3) == 0) ? pc : rand_pc(),
            ($urandom_range(0, 3) != 0),
            pc,
            1'($urandom_range(0, 1)),
            tg,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 0) ? tg : rand_pc());
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
